router_arbiter: RTL

ROUTER_ARBITER -- requirements
Module: router_arbiter

---
 rtl/router_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/router_arbiter.sv
// Three-channel frame arbiter sharing one data bus, fixed-priority or round-robin.
// Optional statistics counters enabled by defining ROUTER_ARB_STATS_EN.
module router_arbiter #(
    parameter int DATA_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              mode,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic [DATA_W-1:0] data_c,
    input  logic              full,
    output logic [2:0]        ack,
    output logic [DATA_W-1:0] bus_data,
    output logic              bus_valid,
    output logic [1:0]        source,
    output logic              busy
`ifdef ROUTER_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]  grant_cnt_a,
    output logic [CNT_W-1:0]  grant_cnt_b,
    output logic [CNT_W-1:0]  grant_cnt_c,
    output logic [CNT_W-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, GRANT, STALL} state_t;

    state_t            state_reg;
    logic [2:0]        ack_reg;
    logic [DATA_W-1:0] bus_data_reg;
    logic              bus_valid_reg;
    logic [1:0]        source_reg;
    logic [1:0]        ptr_reg;

    logic [2:0]        eligible;
    logic [1:0]        grant_idx;
    logic              grant_any;
    logic              grant;
    logic [DATA_W-1:0] data_sel;

    // A channel acked last cycle still shows req high, so the live ack doubles as the mask.
    assign eligible = req & ~ack_reg;
    assign grant    = grant_any && !full;

    always_comb begin
        grant_idx = 2'd0;
        grant_any = 1'b0;
        if (mode == 1'b0) begin
            for (int k = 2; k >= 0; k--) begin
                if (eligible[2'(k)]) begin
                    grant_idx = 2'(k);
                    grant_any = 1'b1;
                end
            end
        end else begin
            // Descending offset so the channel nearest after the pointer wins.
            for (int k = 3; k >= 1; k--) begin
                if (eligible[2'((int'(ptr_reg) + k) % 3)]) begin
                    grant_idx = 2'((int'(ptr_reg) + k) % 3);
                    grant_any = 1'b1;
                end
            end
        end
    end

    always_comb begin
        case (grant_idx)
            2'd0:    data_sel = data_a;
            2'd1:    data_sel = data_b;
            default: data_sel = data_c;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= IDLE;
            ack_reg       <= 3'b000;
            bus_valid_reg <= 1'b0;
            bus_data_reg  <= '0;
            source_reg    <= 2'b00;
            ptr_reg       <= 2'd2;
        end else begin
            ack_reg       <= grant ? (3'b001 << grant_idx) : 3'b000;
            bus_valid_reg <= grant;
            if (grant) begin
                bus_data_reg <= data_sel;
                source_reg   <= grant_idx;
                ptr_reg      <= grant_idx;
            end
            case (state_reg)
                IDLE: begin
                    if (grant)
                        state_reg <= GRANT;
                    else if (full && grant_any)
                        state_reg <= STALL;
                end
                GRANT: begin
                    if (grant)
                        state_reg <= GRANT;
                    else if (full && (req != 3'b000))
                        state_reg <= STALL;
                    else
                        state_reg <= IDLE;
                end
                STALL: begin
                    if (grant)
                        state_reg <= GRANT;
                    else if (req == 3'b000)
                        state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign ack       = ack_reg;
    assign bus_data  = bus_data_reg;
    assign bus_valid = bus_valid_reg;
    assign source    = source_reg;
    assign busy      = (state_reg != IDLE);

`ifdef ROUTER_ARB_STATS_EN
    logic [CNT_W-1:0] grant_cnt_reg [3];
    logic [CNT_W-1:0] stall_cnt_reg;

    for (genvar gi = 0; gi < 3; gi++) begin : g_grant_cnt
        always_ff @(posedge clock) begin
            if (reset)
                grant_cnt_reg[gi] <= '0;
            else if (grant && (grant_idx == 2'(gi)) && (grant_cnt_reg[gi] != '1))
                grant_cnt_reg[gi] <= grant_cnt_reg[gi] + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            stall_cnt_reg <= '0;
        else if ((state_reg == STALL) && (stall_cnt_reg != '1))
            stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end

    assign grant_cnt_a = grant_cnt_reg[0];
    assign grant_cnt_b = grant_cnt_reg[1];
    assign grant_cnt_c = grant_cnt_reg[2];
    assign stall_cnt   = stall_cnt_reg;
`endif

endmodule
